instr_fetch_unit: RTL and testbench

// - Initiator side of the instruction-memory read interface: owns the PC, drives

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : shared fetch-path types and constants                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : synchronous queue of {pc, instr} entries                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wdata,
  output logic                   full,
  output logic                   empty,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_addr_w = $clog2(DEPTH);

  fetch_entry_t        r_mem [DEPTH];
  logic [c_addr_w:0]   r_wr_ptr;
  logic [c_addr_w:0]   r_rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr[c_addr_w-1:0]] <= wdata;
  end

  assign head  = r_mem[r_rd_ptr[c_addr_w-1:0]];
  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                 (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit : PC owner, imem read initiator, fetch queue feeder |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] c_align_mask = ~32'd3;

  logic [31:0]                   r_pc;
  logic [31:0]                   r_fetch_count;
  logic                          w_pop;
  logic                          w_push;
  logic                          w_full;
  logic                          w_empty;
  fetch_entry_t                  w_head;
  fetch_entry_t                  w_wdata;
  logic [$clog2(FIFO_DEPTH):0]   w_count;

  // Valid comes from queue state only, so fetch_ready never reaches fetch_valid.
  assign fetch_valid = (w_count != '0);
  assign w_pop       = fetch_valid & fetch_ready;
  assign w_push      = !redirect_valid & fetch_en & (!w_full | w_pop);
  assign w_wdata     = '{pc: r_pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC & c_align_mask;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc & c_align_mask;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // A pop coinciding with a redirect was still consumed by decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head),
    .count (w_count)
  );

  assign imem_addr   = r_pc & c_align_mask;
  assign fetch_pc    = w_empty ? 32'd0     : w_head.pc;
  assign fetch_instr = w_empty ? INSTR_NOP : w_head.instr;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch_unit : scoreboard bench for instr_fetch_unit          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] c_wrap_pc = 32'hFFFF_FFF8;
  localparam int          c_depth   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fetch_en, redirect_valid, fetch_ready, fetch_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, fetch_pc, fetch_instr, fetch_count;

  logic        wr_fetch_en, wr_redirect_valid, wr_fetch_ready, wr_fetch_valid;
  logic [31:0] wr_redirect_pc, wr_imem_addr, wr_imem_rdata;
  logic [31:0] wr_fetch_pc, wr_fetch_instr, wr_fetch_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_rdata    = mem_word(imem_addr);
  assign wr_imem_rdata = mem_word(wr_imem_addr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(c_depth)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(c_wrap_pc), .FIFO_DEPTH(c_depth)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(wr_fetch_en), .imem_addr(wr_imem_addr),
    .imem_rdata(wr_imem_rdata), .redirect_valid(wr_redirect_valid), .redirect_pc(wr_redirect_pc),
    .fetch_valid(wr_fetch_valid), .fetch_ready(wr_fetch_ready), .fetch_pc(wr_fetch_pc),
    .fetch_instr(wr_fetch_instr), .fetch_count(wr_fetch_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  fetch_entry_t sb[$];
  logic [31:0]  m_pc;
  logic [31:0]  m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc  = 32'h0000_0000;
    m_cnt = 32'd0;
  endtask

  // One clock cycle: drive, compare outputs against the model, advance the model.
  task automatic step(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_entry_t e;
    logic         pop;
    @(negedge clk);
    fetch_en       = en;
    fetch_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, (sb.size() != 0)});
    check("imem_addr", imem_addr, m_pc);
    check("fetch_count", fetch_count, m_cnt);
    if (sb.size() == 0) check("empty_instr", fetch_instr, INSTR_NOP);
    pop = (sb.size() != 0) && rdy;
    if (pop) begin
      e = sb.pop_front();
      check("head_pc", fetch_pc, e.pc);
      check("head_instr", fetch_instr, e.instr);
      m_cnt = m_cnt + 32'd1;
    end
    if (rv) begin
      sb.delete();
      m_pc = rpc & ~32'd3;
    end else if (en && (sb.size() < c_depth)) begin
      sb.push_back({m_pc, mem_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    fetch_en = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    wr_fetch_en = 1'b0; wr_fetch_ready = 1'b0; wr_redirect_valid = 1'b0; wr_redirect_pc = '0;
    model_reset();
    #12;
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_pc", fetch_pc, 32'd0);
    check("rst_instr", fetch_instr, INSTR_NOP);
    check("rst_count", fetch_count, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wrap_addr", wr_imem_addr, c_wrap_pc);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with decode always ready.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
    // Backpressure: queue fills and PC stalls.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
    // Redirect while full.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check("redir_addr_const", imem_addr, 32'h0000_0100);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check("redir_head_const", fetch_pc, 32'h0000_0100);
    // fetch_en low: pops drain, PC holds.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Async reset mid-stream with queue full.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, fetch_valid}, 32'd0);
    check("async_count", fetch_count, 32'd0);
    check("async_instr", fetch_instr, INSTR_NOP);
    check("async_addr", imem_addr, 32'd0);
    fetch_en = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Random backpressure, enables and redirects.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), $urandom);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

    // PC wrap from RESET_PC near the top of the address space.
    @(negedge clk);
    wr_fetch_en = 1'b1;
    wr_fetch_ready = 1'b1;
    #1;
    check("wrap_valid0", {31'b0, wr_fetch_valid}, 32'd0);
    check("wrap_addr0", wr_imem_addr, c_wrap_pc);
    @(negedge clk); #1;
    check("wrap_pc0", wr_fetch_pc, 32'hFFFF_FFF8);
    check("wrap_instr0", wr_fetch_instr, 32'h4FFF_FFFE);
    @(negedge clk); #1;
    check("wrap_pc1", wr_fetch_pc, 32'hFFFF_FFFC);
    check("wrap_instr1", wr_fetch_instr, 32'h4FFF_FFFF);
    @(negedge clk); #1;
    check("wrap_pc2", wr_fetch_pc, 32'h0000_0000);
    check("wrap_instr2", wr_fetch_instr, 32'h1000_0000);
    check("wrap_count", wr_fetch_count, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
